// File: rtl/fifo_traffic_gen_if.sv
// Stimulus bundle carried from the traffic generator to a sync-FIFO under test.
// The generator owns every signal; the FIFO side only observes.
interface fifo_traffic_gen_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  fifo_rst_n;
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] data_in;

   modport master (
      output fifo_rst_n,
      output wr_en,
      output rd_en,
      output data_in
   );

   modport slave (
      input fifo_rst_n,
      input wr_en,
      input rd_en,
      input data_in
   );
endinterface

// File: rtl/fifo_traffic_gen.sv
// LFSR-driven stimulus generator for sync-FIFO DUTs: one DUT reset cycle, then
// NUM_TXN weighted random (or fill/drain/alternate) transactions, then a sticky done flag.
module fifo_traffic_gen #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_TXN    = 2000,
   parameter logic [31:0] SEED = 32'hACE1,
   parameter int RST_THRESH = 3,
   parameter int WR_THRESH  = 179,
   parameter int RD_THRESH  = 77,
   localparam int CW = $clog2(NUM_TXN + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [1:0]        mode_i,
   fifo_traffic_gen_if.master bus,
   output logic              drive_strobe_o,
   output logic              test_finished_o,
   output logic [CW-1:0]     txn_count_o,
   output logic [1:0]        state_o
);

   localparam logic [31:0] LFSR_MASK = 32'h80200003;
   localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;

   typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_e;

   state_e                state_q;
   logic [1:0]            mode_q;
   logic [31:0]           lfsr_q, lfsr_d;
   logic                  fifo_rst_n_q, wr_en_q, rd_en_q, strobe_q, finished_q;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]         count_q;
   logic                  fifo_rst_n_d, wr_en_d, rd_en_d;

   // The stepped LFSR value is what the transaction issued this cycle is built from.
   always_comb begin
      lfsr_d       = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'd0);
      data_d       = lfsr_d[31 -: DATA_WIDTH];
      fifo_rst_n_d = 1'b1;
      wr_en_d      = 1'b0;
      rd_en_d      = 1'b0;
      case (mode_q)
         2'b00: begin
            fifo_rst_n_d = !({1'b0, lfsr_d[7:0]} < 9'(RST_THRESH));
            wr_en_d      = {1'b0, lfsr_d[15:8]} < 9'(WR_THRESH);
            rd_en_d      = {1'b0, lfsr_d[23:16]} < 9'(RD_THRESH);
         end
         2'b01: wr_en_d = 1'b1;
         2'b10: rd_en_d = 1'b1;
         default: begin
            wr_en_d = ~count_q[0];
            rd_en_d = count_q[0];
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || abort_i) begin
         state_q      <= S_IDLE;
         mode_q       <= 2'b00;
         lfsr_q       <= SEED_EFF;
         fifo_rst_n_q <= 1'b1;
         wr_en_q      <= 1'b0;
         rd_en_q      <= 1'b0;
         data_q       <= '0;
         strobe_q     <= 1'b0;
         finished_q   <= 1'b0;
         count_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  state_q      <= S_INIT;
                  mode_q       <= mode_i;
                  fifo_rst_n_q <= 1'b0;
                  wr_en_q      <= 1'b1;
                  rd_en_q      <= 1'b0;
                  data_q       <= DATA_WIDTH'(3);
                  strobe_q     <= 1'b1;
                  finished_q   <= 1'b0;
                  count_q      <= '0;
               end else if (state_q == S_DONE) begin
                  fifo_rst_n_q <= 1'b1;
                  wr_en_q      <= 1'b0;
                  rd_en_q      <= 1'b0;
                  data_q       <= '0;
                  strobe_q     <= 1'b0;
                  finished_q   <= 1'b1;
               end
            end
            S_INIT, S_RUN: begin
               lfsr_q       <= lfsr_d;
               fifo_rst_n_q <= fifo_rst_n_d;
               wr_en_q      <= wr_en_d;
               rd_en_q      <= rd_en_d;
               data_q       <= data_d;
               strobe_q     <= 1'b1;
               count_q      <= count_q + 1'b1;
               state_q      <= (count_q == CW'(NUM_TXN - 1)) ? S_DONE : S_RUN;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.fifo_rst_n    = fifo_rst_n_q;
   assign bus.wr_en         = wr_en_q;
   assign bus.rd_en         = rd_en_q;
   assign bus.data_in       = data_q;
   assign drive_strobe_o    = strobe_q;
   assign test_finished_o   = finished_q;
   assign txn_count_o       = count_q;
   assign state_o           = state_q;

endmodule
